// File: rtl/shift_sequencer.sv
// Multi-cycle 32-bit shifter/rotator: accepts an operation, shifts up to STEP
// positions per cycle, and pulses done with the registered result.
module shift_sequencer #(
    parameter int STEP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] s
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    localparam logic [5:0] STEP_AMT = 6'(STEP);

    logic [1:0]  state;
    logic [1:0]  op_r;
    logic [31:0] work;
    logic [5:0]  cnt;
    logic [5:0]  k;
    logic [31:0] work_next;
    logic        accept;
    logic        overrange;

    // One partial shift of k positions; k is always in 1..16 when used.
    function automatic logic [31:0] shift_by(input logic [1:0] sel,
                                             input logic [31:0] v,
                                             input logic [5:0] amt);
        case (sel)
            OP_SLL:  return v << amt;
            OP_SRL:  return v >> amt;
            OP_SRA:  return $unsigned($signed(v) >>> amt);
            default: return (v >> amt) | (v << (6'd32 - amt));
        endcase
    endfunction

    function automatic logic [31:0] saturate(input logic [1:0] sel,
                                             input logic [31:0] v);
        return (sel == OP_SRA) ? {32{v[31]}} : 32'h0000_0000;
    endfunction

    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign overrange = (op != OP_ROR) && (|b[31:5]);
    assign k         = (cnt < STEP_AMT) ? cnt : STEP_AMT;
    assign work_next = shift_by(op_r, work, k);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op_r  <= OP_SLL;
            work  <= 32'h0000_0000;
            cnt   <= 6'd0;
            s     <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        if (overrange) begin
                            s     <= saturate(op, a);
                            state <= DONE;
                        end else if (b[4:0] == 5'd0) begin
                            s     <= a;
                            state <= DONE;
                        end else begin
                            work  <= a;
                            cnt   <= {1'b0, b[4:0]};
                            op_r  <= op;
                            state <= SHIFT;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    work <= work_next;
                    cnt  <= cnt - k;
                    if (cnt == k) begin
                        s     <= work_next;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed self-checking bench for shift_sequencer (STEP=4 instance plus a
// STEP=1 instance for the slow-path latency case).
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        start1 = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'h0;
    logic [31:0] b = 32'h0;
    logic        busy, done, busy1, done1;
    logic [31:0] s, s1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.STEP(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .s(s)
    );

    shift_sequencer #(.STEP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .op(op), .a(a), .b(b),
        .busy(busy1), .done(done1), .s(s1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble the inputs after acceptance, and measure
    // busy cycles and edges from the accepting edge until done is seen.
    task automatic run_op(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                          output int bcyc, output int lat);
        @(negedge clk);
        op = o; a = av; b = bv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = ~o; a = 32'hDEAD_BEEF; b = 32'h0000_0003;
        lat = 1; bcyc = 0;
        while (!done && lat < 100) begin
            if (busy) bcyc++;
            @(posedge clk); #1;
            lat++;
        end
        if (!done) check("timeout", {31'b0, done}, 32'd1);
    endtask

    int bc, lt, seen;
    logic [31:0] hold;

    initial begin
        #2;
        check("rst_s", s, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        @(negedge clk); rst = 1'b0;

        run_op(2'b10, 32'h8000_0000, 32'd4, bc, lt);
        check("sra4_s", s, 32'hF800_0000);
        check("sra4_busy", bc, 32'd1);
        check("sra4_lat", lt, 32'd2);

        run_op(2'b01, 32'h8000_0000, 32'd31, bc, lt);
        check("srl31_s", s, 32'h0000_0001);
        check("srl31_busy", bc, 32'd8);
        check("srl31_lat", lt, 32'd9);

        run_op(2'b10, 32'h8000_0001, 32'h20, bc, lt);
        check("sra_sat_s", s, 32'hFFFF_FFFF);
        check("sra_sat_lat", lt, 32'd1);
        check("sra_sat_busy", bc, 32'd0);
        run_op(2'b00, 32'h8000_0001, 32'h20, bc, lt);
        check("sll_sat_s", s, 32'h0);
        check("sll_sat_lat", lt, 32'd1);
        run_op(2'b00, 32'h1234_5678, 32'h0, bc, lt);
        check("sll0_s", s, 32'h1234_5678);
        check("sll0_lat", lt, 32'd1);
        check("sll0_busy", bc, 32'd0);

        run_op(2'b11, 32'h0000_0001, 32'h21, bc, lt);
        check("ror33_s", s, 32'h8000_0000);
        check("ror33_busy", bc, 32'd1);
        run_op(2'b11, 32'h1234_5678, 32'd8, bc, lt);
        check("ror8_s", s, 32'h7812_3456);
        check("ror8_busy", bc, 32'd2);
        run_op(2'b10, 32'h7000_0000, 32'd9, bc, lt);
        check("sra9_s", s, 32'h0038_0000);
        check("sra9_busy", bc, 32'd3);

        hold = s;
        repeat (3) @(posedge clk);
        #1;
        check("hold_s", s, hold);
        check("idle_done", {31'b0, done}, 32'h0);

        // Start pulse while busy is ignored, then back-to-back from DONE.
        @(negedge clk); op = 2'b00; a = 32'h1; b = 32'd8; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk); a = 32'hFF; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        check("ign_busy", {31'b0, busy}, 32'h1);
        @(posedge clk); #1;
        check("ign_done", {31'b0, done}, 32'h1);
        check("ign_s", s, 32'h0000_0100);
        @(negedge clk); op = 2'b01; a = 32'h100; b = 32'd4; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        check("b2b_busy", {31'b0, busy}, 32'h1);
        @(posedge clk); #1;
        check("b2b_done", {31'b0, done}, 32'h1);
        check("b2b_s", s, 32'h0000_0010);
        @(posedge clk); #1;
        check("b2b_idle", {31'b0, done}, 32'h0);

        // Asynchronous reset in the middle of an SRL by 20.
        @(negedge clk); op = 2'b01; a = 32'hFFFF_FFFF; b = 32'd20; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #2; rst = 1'b1;
        #1;
        check("arst_busy", {31'b0, busy}, 32'h0);
        check("arst_s", s, 32'h0);
        seen = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("arst_nodone", seen, 32'd0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd20, bc, lt);
        check("post_rst_s", s, 32'h0000_0FFF);
        check("post_rst_busy", bc, 32'd5);

        // STEP=1 instance: one position per cycle.
        @(negedge clk); op = 2'b01; a = 32'h8000_0000; b = 32'd31; start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        bc = 0; lt = 1;
        while (!done1 && lt < 100) begin
            if (busy1) bc++;
            @(posedge clk); #1;
            lt++;
        end
        check("step1_done", {31'b0, done1}, 32'h1);
        check("step1_busy", bc, 32'd31);
        check("step1_s", s1, 32'h0000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter STEP, default 4, maximum bit positions shifted per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request pulse; SHALL be sampled only while busy=0.
REQ-005 op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
REQ-006 a  input  32  operand; SHALL be captured on the accepting edge.
REQ-007 b  input  32  shift amount; SHALL be captured on the accepting edge.
REQ-008 busy  output  1  high while in SHIFT.
REQ-009 done  output  1  one-cycle pulse; result is valid.
REQ-010 s  output  32  result register; SHALL hold its value between updates.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and DONE. busy SHALL be 1 only in SHIFT, and done SHALL be 1 only in DONE.
REQ-012 Accept condition: start=1 and state is IDLE or DONE. When start=1 in SHIFT, the block SHALL ignore it: no capture and no state change.
REQ-013 Overrange: if op is SLL, SRL or SRA and any of b[31:5] is nonzero, the accepting edge SHALL load s with the saturated result and go to DONE. The saturated result is 0x00000000 for SLL and SRL, and 32 copies of a[31] for SRA.
REQ-014 ROR SHALL use b[4:0] only; b[31:5] SHALL be ignored.
REQ-015 Zero amount: if the effective amount n (b[4:0]) is 0 and REQ-013 does not apply, the accepting edge SHALL load s=a and go to DONE.
REQ-016 Otherwise the accepting edge SHALL load the working register with a and the counter with n, and go to SHIFT.
REQ-017 On each SHIFT edge the block SHALL apply k=min(count, STEP) positions and set count to count-k.
  - SLL: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: fill with the captured a[31].
  - ROR: wrap bit 0 into bit 31.
REQ-018 When count reaches 0 on a SHIFT edge, that same edge SHALL load s with the working register and go to DONE.
REQ-019 Latency SHALL be exact: done is high in the cycle following edge number 1+ceil(n/STEP), counting the accepting edge as edge 1. The direct-to-DONE cases take 1 edge.
REQ-020 DONE SHALL return to IDLE on the next edge unless start=1. If start=1, REQ-012 applies, giving back-to-back operation with no IDLE cycle.
REQ-021 s SHALL change only on an edge that enters DONE, or on reset.
REQ-022 Changes on a, b or op after the accepting edge SHALL NOT affect the operation in progress.
REQ-023 The counter SHALL be 6 bits wide. Shift arithmetic SHALL never read outside bits [31:0].

Reset
REQ-024 When rst=1, the block SHALL immediately, without waiting for clk, force: state=IDLE, busy=0, done=0, s=0x00000000, working register=0, counter=0.
REQ-025 Reset asserted during SHIFT SHALL abort the operation: no done pulse and s=0.
REQ-026 On the first edge after rst falls, a start=1 SHALL be accepted normally.

Verification (STEP=4 unless noted)
REQ-027 SRA, a=0x80000000, b=4 -> busy for 1 cycle; done 2 edges after the accepting edge; s=0xF8000000.
REQ-028 SRL, a=0x80000000, b=31 -> busy for 8 cycles; s=0x00000001.
  - Repeat with STEP=1: busy for 31 cycles, same s.
REQ-029 Direct-to-DONE cases, each done in the cycle right after acceptance, busy never high:
  - SRA, a=0x80000001, b=0x00000020 -> s=0xFFFFFFFF.
  - SLL, same a and b -> s=0x00000000.
  - SLL, a=0x12345678, b=0 -> s=0x12345678.
REQ-030 ROR, a=0x00000001, b=0x00000021 -> s=0x80000000 after 1 SHIFT cycle.
REQ-031 Start ignored while busy, then back-to-back:
  - Issue SLL, a=1, b=8; pulse start=1 with a different a mid-SHIFT -> s=0x00000100; the second request is not accepted.
  - Then assert start in the DONE cycle -> the next operation is accepted with no IDLE gap.
REQ-032 Reset mid-SHIFT:
  - During SRL, b=20, assert rst asynchronously between edges -> busy=0 and s=0 immediately; done never pulses.
  - A new request after deassertion completes correctly.
